axil_ctrl_bridge: RTL and testbench

//  Control-path stage between the PCIe AXI4-Lite master (32b addr/data) and the simulator shim's AXI4 MMIO

---
 rtl/axil_ctrl_bridge.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axil_ctrl_bridge.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ctrl_bridge.sv
// AXI4-Lite to single-beat AXI4 control bridge with address range check and
// bounded downstream response waits. Write and read paths run independently.
module axil_ctrl_bridge #(
  parameter int ADDR_W         = 25,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [31:0]       s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic [11:0]       m_awid,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [11:0]       m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  output logic [CNT_W-1:0]  timeout_count,
  output logic [1:0]        dbg_wr_state_o,
  output logic [1:0]        dbg_rd_state_o
);

  // Handshakes: a transfer happens on a rising clock when valid && ready; a
  // raised valid is never withdrawn before its transfer, and payload holds steady.
  localparam logic [1:0] W_IDLE = 2'd0, W_ISSUE = 2'd1, W_WAIT = 2'd2, W_BRESP = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0, R_ISSUE = 2'd1, R_WAIT = 2'd2, R_RESP  = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        w_state_q, w_state_d, r_state_q, r_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic              aw_oor_q, aw_oor_d, ar_oor_q, ar_oor_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [TW-1:0]     w_timer_q, w_timer_d, r_timer_q, r_timer_d;
  logic [3:0]        w_orph_q, w_orph_d, r_orph_q, r_orph_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W:0]    tcnt_sum;
  logic              wr_to, rd_to;
  logic              aw_hs, w_hs, ar_hs;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_oor_d  = aw_oor_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    w_timer_d = w_timer_q;
    w_orph_d  = w_orph_q;
    wr_to     = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr[ADDR_W-1:0];
      aw_oor_d  = (s_awaddr >> ADDR_W) != 32'd0;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
    case (w_state_q)
      W_IDLE: begin
        if (aw_held_d && w_held_d) begin
          if (aw_oor_d) begin
            bresp_d   = 2'b11;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            w_state_d = W_BRESP;
          end else if (w_orph_q != 4'hF) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = W_ISSUE;
          end
        end
      end
      W_ISSUE: begin
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          w_timer_d = '0;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_timer_q != '1) w_timer_d = w_timer_q + TW'(1);
        // A B seen while orphans are outstanding belongs to an older, abandoned burst.
        if (m_bvalid) begin
          if (w_orph_q != 4'd0) begin
            w_orph_d = w_orph_q - 4'd1;
          end else begin
            bresp_d   = m_bresp;
            w_state_d = W_BRESP;
          end
        end else if (w_timer_q >= T_LAST) begin
          bresp_d   = 2'b10;
          w_orph_d  = w_orph_q + 4'd1;
          wr_to     = 1'b1;
          w_state_d = W_BRESP;
        end
      end
      W_BRESP: begin
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_state_q != W_WAIT && m_bvalid && w_orph_q != 4'd0) w_orph_d = w_orph_q - 4'd1;
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_held_d = ar_held_q;
    ar_oor_d  = ar_oor_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_timer_d = r_timer_q;
    r_orph_d  = r_orph_q;
    rd_to     = 1'b0;
    if (ar_hs) begin
      ar_held_d = 1'b1;
      araddr_d  = s_araddr[ADDR_W-1:0];
      ar_oor_d  = (s_araddr >> ADDR_W) != 32'd0;
    end
    case (r_state_q)
      R_IDLE: begin
        if (ar_held_d) begin
          if (ar_oor_d) begin
            rresp_d   = 2'b11;
            rdata_d   = 32'h0;
            ar_held_d = 1'b0;
            r_state_d = R_RESP;
          end else if (r_orph_q != 4'hF) begin
            ar_held_d = 1'b0;
            r_state_d = R_ISSUE;
          end
        end
      end
      R_ISSUE: begin
        if (m_arready) begin
          r_timer_d = '0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_timer_q != '1) r_timer_d = r_timer_q + TW'(1);
        if (m_rvalid) begin
          if (r_orph_q != 4'd0) begin
            r_orph_d = r_orph_q - 4'd1;
          end else begin
            rresp_d   = m_rresp;
            rdata_d   = m_rdata;
            r_state_d = R_RESP;
          end
        end else if (r_timer_q >= T_LAST) begin
          rresp_d   = 2'b10;
          rdata_d   = 32'h0;
          r_orph_d  = r_orph_q + 4'd1;
          rd_to     = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_state_q != R_WAIT && m_rvalid && r_orph_q != 4'd0) r_orph_d = r_orph_q - 4'd1;
  end

  always_comb begin
    tcnt_sum = {1'b0, tcnt_q} + {{CNT_W{1'b0}}, wr_to} + {{CNT_W{1'b0}}, rd_to};
    tcnt_d   = tcnt_sum[CNT_W] ? '1 : tcnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      aw_oor_q  <= 1'b0;
      ar_oor_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      w_timer_q <= '0;
      r_timer_q <= '0;
      w_orph_q  <= '0;
      r_orph_q  <= '0;
      tcnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      aw_oor_q  <= aw_oor_d;
      ar_oor_q  <= ar_oor_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      w_timer_q <= w_timer_d;
      r_timer_q <= r_timer_d;
      w_orph_q  <= w_orph_d;
      r_orph_q  <= r_orph_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign s_awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign s_wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign s_bvalid  = (w_state_q == W_BRESP);
  assign s_bresp   = bresp_q;
  assign s_arready = (r_state_q == R_IDLE) && !ar_held_q;
  assign s_rvalid  = (r_state_q == R_RESP);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign m_awvalid = (w_state_q == W_ISSUE) && !aw_done_q;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'd2;
  assign m_awburst = 2'd1;
  assign m_awid    = 12'd0;
  assign m_wvalid  = (w_state_q == W_ISSUE) && !w_done_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wlast   = 1'b1;
  assign m_bready  = (w_state_q == W_WAIT) || (w_orph_q != 4'd0);

  assign m_arvalid = (r_state_q == R_ISSUE);
  assign m_araddr  = araddr_q;
  assign m_arlen   = 8'd0;
  assign m_arsize  = 3'd2;
  assign m_arburst = 2'd1;
  assign m_arid    = 12'd0;
  assign m_rready  = (r_state_q == R_WAIT) || (r_orph_q != 4'd0);

  assign timeout_count  = tcnt_q;
  assign dbg_wr_state_o = w_state_q;
  assign dbg_rd_state_o = r_state_q;

endmodule

// File: tb/tb_axil_ctrl_bridge.sv
// Self-checking bench for axil_ctrl_bridge: directed scenarios with a response
// scoreboard, short timeout parameter so forced responses are reachable quickly.
module tb_axil_ctrl_bridge;
  localparam int ADDR_W = 25;
  localparam int TO     = 8;
  localparam int CNT_W  = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [11:0] m_awid, m_arid;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0] m_wstrb;
  logic [CNT_W-1:0] timeout_count;
  logic [1:0] dbg_wr_state_o, dbg_rd_state_o;

  axil_ctrl_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .timeout_count(timeout_count),
    .dbg_wr_state_o(dbg_wr_state_o), .dbg_rd_state_o(dbg_rd_state_o)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [1:0]  eb;
  logic [33:0] er;
  logic [CNT_W-1:0] exp_tc;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int arv_cnt   = 0;

  always @(posedge clock) begin
    if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (m_wvalid && m_wready)   w_hs_cnt  <= w_hs_cnt + 1;
    if (m_arvalid)              arv_cnt   <= arv_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic init_inputs();
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
  endtask

  task automatic wait_bvalid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_bvalid === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_rvalid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_rvalid === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    init_inputs();
    reset = 1;
    tick(); tick(); tick();
    reset = 0;
    exp_tc = '0;
    checks++;
    if ({s_awready, s_wready, s_arready, m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid} !== 8'b11100000)
      begin errors++; $display("FAIL reset_handshakes got %b want 11100000",
        {s_awready, s_wready, s_arready, m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}); end
    checks++;
    if ({timeout_count, s_bresp, s_rresp, s_rdata} !== '0)
      begin errors++; $display("FAIL reset_values tc=%0d bresp=%0d rresp=%0d rdata=%h want 0",
        timeout_count, s_bresp, s_rresp, s_rdata); end
    checks++;
    if ({m_bready, m_rready} !== 2'b00)
      begin errors++; $display("FAIL reset_mready got %b want 00", {m_bready, m_rready}); end
  endtask

  task automatic test_single_write();
    m_awready = 1; m_wready = 1;
    s_awvalid = 1; s_awaddr = 32'h0000_0100; s_wvalid = 1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
    exp_b_q.push_back(2'b00);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({m_awvalid, m_wvalid} !== 2'b11)
      begin errors++; $display("FAIL t1_issue_c1 got %b want 11", {m_awvalid, m_wvalid}); end
    checks++;
    if ({m_awaddr, m_wdata, m_wstrb, m_wlast} !== {25'h100, 32'hCAFE_F00D, 4'hF, 1'b1})
      begin errors++; $display("FAIL t1_payload addr=%h data=%h strb=%h last=%b", m_awaddr, m_wdata, m_wstrb, m_wlast); end
    checks++;
    if ({m_awlen, m_awsize, m_awburst, m_awid} !== {8'd0, 3'd2, 2'd1, 12'd0})
      begin errors++; $display("FAIL t1_aw_attrs len=%0d size=%0d burst=%0d id=%0d want 0/2/1/0",
        m_awlen, m_awsize, m_awburst, m_awid); end
    tick();
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, s_bvalid} !== 4'b0010)
      begin errors++; $display("FAIL t1_wait_c2 got %b want 0010", {m_awvalid, m_wvalid, m_bready, s_bvalid}); end
    tick();
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    checks++;
    if (s_bvalid !== 1'b1) begin errors++; $display("FAIL t1_bvalid_c4 got %b want 1", s_bvalid); end
    eb = exp_b_q.size() != 0 ? exp_b_q.pop_front() : 2'bxx;
    checks++;
    if (s_bresp !== eb) begin errors++; $display("FAIL t1_bresp got %0d want %0d", s_bresp, eb); end
    s_bready = 1;
    tick();
    s_bready = 0;
    checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b011)
      begin errors++; $display("FAIL t1_after_b got %b want 011", {s_bvalid, s_awready, s_wready}); end
  endtask

  task automatic test_split_aw_w_backpressure();
    int aw0, w0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    m_awready = 1; m_wready = 1;
    s_wvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'h3;
    tick();
    s_wvalid = 0;
    checks++;
    if ({s_wready, s_awready, m_awvalid, m_wvalid} !== 4'b0100)
      begin errors++; $display("FAIL t2_w_held got %b want 0100", {s_wready, s_awready, m_awvalid, m_wvalid}); end
    tick();
    s_awvalid = 1; s_awaddr = 32'h0000_0040;
    exp_b_q.push_back(2'b01);
    tick();
    s_awvalid = 0;
    checks++;
    if ({m_awvalid, m_wvalid, m_awaddr, m_wstrb} !== {2'b11, 25'h40, 4'h3})
      begin errors++; $display("FAIL t2_issue got v=%b addr=%h strb=%h", {m_awvalid, m_wvalid}, m_awaddr, m_wstrb); end
    tick();
    m_bvalid = 1; m_bresp = 2'b01;
    tick();
    m_bvalid = 0;
    s_awvalid = 1; s_awaddr = 32'h0000_0080;
    eb = exp_b_q.size() != 0 ? exp_b_q.pop_front() : 2'bxx;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({s_bvalid, s_bresp, s_awready} !== {1'b1, eb, 1'b0})
        begin errors++; $display("FAIL t2_hold_%0d got valid=%b resp=%0d awready=%b want 1/%0d/0",
          i, s_bvalid, s_bresp, s_awready, eb); end
      tick();
    end
    s_bready = 1;
    tick();
    s_bready = 0; s_awvalid = 0;
    checks++;
    if ((aw_hs_cnt - aw0) != 1 || (w_hs_cnt - w0) != 1)
      begin errors++; $display("FAIL t2_single_pair got aw=%0d w=%0d want 1/1", aw_hs_cnt - aw0, w_hs_cnt - w0); end
    checks++;
    if ({s_bvalid, s_awready} !== 2'b01)
      begin errors++; $display("FAIL t2_after_b got %b want 01", {s_bvalid, s_awready}); end
  endtask

  task automatic test_decerr();
    bit ok;
    int arv0, aw0;
    arv0 = arv_cnt; aw0 = aw_hs_cnt;
    s_arvalid = 1; s_araddr = 32'h0200_0000;
    exp_r_q.push_back({2'b11, 32'h0});
    tick();
    s_arvalid = 0;
    wait_rvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_rvalid_timeout got none want s_rvalid"); end
    er = exp_r_q.size() != 0 ? exp_r_q.pop_front() : 34'bx;
    checks++;
    if ({s_rresp, s_rdata} !== er) begin errors++; $display("FAIL t3_decerr_r got %h want %h", {s_rresp, s_rdata}, er); end
    s_rready = 1;
    tick();
    s_rready = 0;
    checks++;
    if (arv_cnt != arv0 || s_rvalid !== 1'b0 || s_arready !== 1'b1)
      begin errors++; $display("FAIL t3_no_forward arvalid_cycles=%0d rvalid=%b arready=%b want 0/0/1",
        arv_cnt - arv0, s_rvalid, s_arready); end
    s_awvalid = 1; s_awaddr = 32'hFFFF_0000; s_wvalid = 1; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
    exp_b_q.push_back(2'b11);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    wait_bvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_bvalid_timeout got none want s_bvalid"); end
    eb = exp_b_q.size() != 0 ? exp_b_q.pop_front() : 2'bxx;
    checks++;
    if (s_bresp !== eb || aw_hs_cnt != aw0)
      begin errors++; $display("FAIL t3_decerr_b got resp=%0d aw_fwd=%0d want %0d/0", s_bresp, aw_hs_cnt - aw0, eb); end
    s_bready = 1;
    tick();
    s_bready = 0;
  endtask

  task automatic test_write_timeout();
    int n;
    m_awready = 1; m_wready = 1;
    s_awvalid = 1; s_awaddr = 32'h0000_0300; s_wvalid = 1; s_wdata = 32'h0BAD_0BAD; s_wstrb = 4'hF;
    exp_b_q.push_back(2'b10);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    n = 0;
    while (s_bvalid !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != TO) begin errors++; $display("FAIL t4_wait_cycles got %0d want %0d", n, TO); end
    eb = exp_b_q.size() != 0 ? exp_b_q.pop_front() : 2'bxx;
    checks++;
    if (s_bresp !== eb) begin errors++; $display("FAIL t4_slverr got %0d want %0d", s_bresp, eb); end
    exp_tc = exp_tc + 1;
    checks++;
    if (timeout_count !== exp_tc) begin errors++; $display("FAIL t4_tcount got %0d want %0d", timeout_count, exp_tc); end
    s_bready = 1;
    tick();
    s_bready = 0;
    checks++;
    if (m_bready !== 1'b1) begin errors++; $display("FAIL t4_orphan_bready got %b want 1", m_bready); end
    s_awvalid = 1; s_awaddr = 32'h0000_0304; s_wvalid = 1; s_wdata = 32'h600D_600D;
    exp_b_q.push_back(2'b00);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    m_bvalid = 1; m_bresp = 2'b01;
    tick();
    checks++;
    if (s_bvalid !== 1'b0) begin errors++; $display("FAIL t4_stray_forwarded got %b want 0", s_bvalid); end
    m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    checks++;
    if (s_bvalid !== 1'b1) begin errors++; $display("FAIL t4_real_b got %b want 1", s_bvalid); end
    eb = exp_b_q.size() != 0 ? exp_b_q.pop_front() : 2'bxx;
    checks++;
    if (s_bresp !== eb) begin errors++; $display("FAIL t4_real_bresp got %0d want %0d", s_bresp, eb); end
    s_bready = 1;
    tick();
    s_bready = 0;
    checks++;
    if (m_bready !== 1'b0 || timeout_count !== exp_tc)
      begin errors++; $display("FAIL t4_orphans_cleared bready=%b tc=%0d want 0/%0d", m_bready, timeout_count, exp_tc); end
  endtask

  task automatic test_read_timeout();
    bit ok;
    m_arready = 1;
    s_arvalid = 1; s_araddr = 32'h0000_0400;
    exp_r_q.push_back({2'b10, 32'h0});
    tick();
    s_arvalid = 0;
    wait_rvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t4r_rvalid_timeout got none want s_rvalid"); end
    er = exp_r_q.size() != 0 ? exp_r_q.pop_front() : 34'bx;
    checks++;
    if ({s_rresp, s_rdata} !== er) begin errors++; $display("FAIL t4r_slverr got %h want %h", {s_rresp, s_rdata}, er); end
    exp_tc = exp_tc + 1;
    checks++;
    if (timeout_count !== exp_tc) begin errors++; $display("FAIL t4r_tcount got %0d want %0d", timeout_count, exp_tc); end
    s_rready = 1;
    tick();
    s_rready = 0;
    checks++;
    if (m_rready !== 1'b1) begin errors++; $display("FAIL t4r_orphan_rready got %b want 1", m_rready); end
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    checks++;
    if ({m_rready, s_rvalid} !== 2'b00)
      begin errors++; $display("FAIL t4r_stray_drained got %b want 00", {m_rready, s_rvalid}); end
  endtask

  task automatic test_back_to_back();
    m_awready = 1; m_wready = 1; m_arready = 1;
    s_awvalid = 1; s_awaddr = 32'h0000_0010; s_wvalid = 1; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'h8;
    s_arvalid = 1; s_araddr = 32'h0123_4560;
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({2'b01, 32'h89AB_CDEF});
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    checks++;
    if ({m_arvalid, m_araddr, m_awvalid} !== {1'b1, 25'h123_4560, 1'b1})
      begin errors++; $display("FAIL t5_issue arvalid=%b araddr=%h awvalid=%b", m_arvalid, m_araddr, m_awvalid); end
    checks++;
    if ({m_arlen, m_arsize, m_arburst, m_arid} !== {8'd0, 3'd2, 2'd1, 12'd0})
      begin errors++; $display("FAIL t5_ar_attrs len=%0d size=%0d burst=%0d id=%0d want 0/2/1/0",
        m_arlen, m_arsize, m_arburst, m_arid); end
    tick();
    m_bvalid = 1; m_bresp = 2'b00;
    m_rvalid = 1; m_rdata = 32'h89AB_CDEF; m_rresp = 2'b01;
    tick();
    m_bvalid = 0; m_rvalid = 0;
    checks++;
    if ({s_bvalid, s_rvalid} !== 2'b11)
      begin errors++; $display("FAIL t5_both_valid got %b want 11", {s_bvalid, s_rvalid}); end
    eb = exp_b_q.size() != 0 ? exp_b_q.pop_front() : 2'bxx;
    er = exp_r_q.size() != 0 ? exp_r_q.pop_front() : 34'bx;
    checks++;
    if (s_bresp !== eb) begin errors++; $display("FAIL t5_bresp got %0d want %0d", s_bresp, eb); end
    checks++;
    if ({s_rresp, s_rdata} !== er) begin errors++; $display("FAIL t5_rdata got %h want %h", {s_rresp, s_rdata}, er); end
    s_bready = 1; s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
    checks++;
    if ({s_bvalid, s_rvalid} !== 2'b00)
      begin errors++; $display("FAIL t5_after got %b want 00", {s_bvalid, s_rvalid}); end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    m_awready = 1; m_wready = 1; m_arready = 0;
    s_awvalid = 1; s_awaddr = 32'h0000_0500; s_wvalid = 1; s_wdata = 32'h1111_2222; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 32'h0000_0600;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    tick();
    checks++;
    if ({dbg_wr_state_o, dbg_rd_state_o, timeout_count} !== {2'd2, 2'd1, exp_tc})
      begin errors++; $display("FAIL t6_pre got wr=%0d rd=%0d tc=%0d want 2/1/%0d",
        dbg_wr_state_o, dbg_rd_state_o, timeout_count, exp_tc); end
    reset = 1;
    tick();
    reset = 0;
    exp_tc = '0;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 8'b00000111)
      begin errors++; $display("FAIL t6_valids got %b want 00000111",
        {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid, s_awready, s_wready, s_arready}); end
    checks++;
    if (timeout_count !== exp_tc) begin errors++; $display("FAIL t6_tcount got %0d want %0d", timeout_count, exp_tc); end
    m_arready = 1;
    seen = 0;
    for (int i = 0; i < 2 * TO; i++) begin
      if (s_bvalid === 1'b1 || s_rvalid === 1'b1 || m_arvalid === 1'b1) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL t6_abandoned got response activity want none"); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_split_aw_w_backpressure();
    test_decerr();
    test_write_timeout();
    test_read_timeout();
    test_back_to_back();
    test_reset_midflight();
    checks++;
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0)
      begin errors++; $display("FAIL scoreboard_drain got b=%0d r=%0d left want 0/0", exp_b_q.size(), exp_r_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
